// File: rtl/twiddle_fetch_if.sv
// Twiddle ROM address/data port plus the twiddle stream toward one FFT stage's butterfly.
// The master side is the fetch unit; the slave side is the ROM and the butterfly.
interface twiddle_fetch_if #(
   parameter int ADDR_W = 8,
   parameter int IDX_W  = 9
);
   logic [ADDR_W-1:0]  rom_addr;
   logic signed [15:0] rom_w_re;
   logic signed [15:0] rom_w_im;

   logic               tw_valid;
   logic               tw_ready;
   logic signed [15:0] tw_re;
   logic signed [15:0] tw_im;
   logic [IDX_W-1:0]   tw_index;
   logic               tw_last;

   modport master (
      output rom_addr,
      input  rom_w_re,
      input  rom_w_im,
      output tw_valid,
      input  tw_ready,
      output tw_re,
      output tw_im,
      output tw_index,
      output tw_last
   );

   modport slave (
      input  rom_addr,
      output rom_w_re,
      output rom_w_im,
      input  tw_valid,
      output tw_ready,
      input  tw_re,
      input  tw_im,
      input  tw_index,
      input  tw_last
   );
endinterface

// File: rtl/twiddle_fetch.sv
// Per-stage twiddle fetcher: walks butterflies 0..FFT_N/2-1, addresses the twiddle ROM
// and streams the returned coefficients through a 2-entry skid FIFO with valid/ready.
module twiddle_fetch #(
   parameter int FFT_N    = 1024,
   parameter int STAGE_NO = 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   output logic           busy,
   output logic           done,
   twiddle_fetch_if.master bus
);
   localparam int LOG_N  = $clog2(FFT_N);
   localparam int ADDR_W = LOG_N - STAGE_NO - 1;
   localparam int IDX_W  = LOG_N - 1;
   localparam logic [IDX_W-1:0] LAST_J = IDX_W'(FFT_N / 2 - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   typedef struct packed {
      logic signed [15:0] re;
      logic signed [15:0] im;
      logic [IDX_W-1:0]   j;
      logic               last;
   } entry_t;

   state_t           state;
   state_t           state_nxt;

   logic [IDX_W-1:0] iss_j;
   logic             inf_valid;
   logic [IDX_W-1:0] inf_j;
   logic             inf_last;

   entry_t           fifo_mem [2];
   entry_t           head;
   logic             wr_ptr;
   logic             rd_ptr;
   logic [1:0]       count;
   logic             fifo_valid;

   logic             push;
   logic             pop;
   logic             issue;
   logic [1:0]       occ_after;

   // A ROM read issued last cycle always lands in the FIFO this cycle; the ROM path never stalls.
   assign push       = inf_valid;
   assign fifo_valid = (count != 2'd0);
   assign pop        = fifo_valid && bus.tw_ready;
   assign head       = fifo_mem[rd_ptr];

   // Occupancy after this edge, counting the landing read and any pop, so a full
   // FIFO being drained still admits one new read per cycle.
   assign occ_after  = count + 2'(push) - 2'(pop);
   assign issue      = (state == ISSUE) && (occ_after < 2'd2);

   // ---------------------------------------------------------------- state register
   always_ff @(posedge clk) begin
      // NOTE: clocked state is written with non-blocking assignments so every register
      // samples pre-edge values regardless of process ordering.
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      // NOTE: every combinationally assigned signal gets a default first; without it a
      // missed branch would hold its old value and infer a latch.
      state_nxt = state;
      case (state)
         IDLE:    if (start)                         state_nxt = ISSUE;
         ISSUE:   if (issue && (iss_j == LAST_J))    state_nxt = DRAIN;
         DRAIN:   if (pop && head.last)              state_nxt = DONE;
         DONE:                                       state_nxt = IDLE;
         default:                                    state_nxt = IDLE;
      endcase
   end

   // ---------------------------------------------------------------- outputs
   always_comb begin
      busy          = 1'b0;
      done          = 1'b0;
      bus.tw_valid  = fifo_valid;
      bus.tw_re     = '0;
      bus.tw_im     = '0;
      bus.tw_index  = '0;
      bus.tw_last   = 1'b0;
      if (fifo_valid) begin
         bus.tw_re    = head.re;
         bus.tw_im    = head.im;
         bus.tw_index = head.j;
         bus.tw_last  = head.last;
      end
      case (state)
         ISSUE, DRAIN: busy = 1'b1;
         DONE:         done = 1'b1;
         default:      ;
      endcase
   end

   // ---------------------------------------------------------------- issue side
   always_ff @(posedge clk) begin
      if (rst) begin
         iss_j        <= '0;
         inf_valid    <= 1'b0;
         inf_j        <= '0;
         inf_last     <= 1'b0;
         bus.rom_addr <= '0;
      end else begin
         inf_valid <= issue;
         if ((state == IDLE) && start) iss_j <= '0;
         if (issue) begin
            // Low address bits repeat the ROM table 2**STAGE_NO times across the frame.
            bus.rom_addr <= iss_j[ADDR_W-1:0];
            inf_j        <= iss_j;
            inf_last     <= (iss_j == LAST_J);
            if (iss_j != LAST_J) iss_j <= iss_j + 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------- FIFO control
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         count <= count + 2'(push) - 2'(pop);
      end
   end

   // NOTE: the FIFO storage has no reset; stale entries are unreachable once the
   // pointers and count clear, and the outputs are forced to zero while empty.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= '{re: bus.rom_w_re, im: bus.rom_w_im, j: inf_j, last: inf_last};
      end
   end
endmodule

// File: tb/tb_twiddle_fetch.sv
// Directed bench for twiddle_fetch: a 16-point stage-1 instance with a real twiddle ROM,
// and a 1024-point stage-8 instance driven with random backpressure.
module tb_twiddle_fetch;
   logic clk     = 1'b0;
   logic rst     = 1'b1;
   logic start16 = 1'b0;
   logic start1k = 1'b0;
   logic rdy16   = 1'b0;
   logic rdy1k   = 1'b0;
   logic busy16, done16, busy1k, done1k;

   int errors = 0;
   int checks = 0;

   twiddle_fetch_if #(.ADDR_W(2), .IDX_W(3)) b16 ();
   twiddle_fetch_if #(.ADDR_W(1), .IDX_W(9)) b1k ();

   twiddle_fetch #(.FFT_N(16), .STAGE_NO(1)) dut16 (
      .clk   (clk),
      .rst   (rst),
      .start (start16),
      .busy  (busy16),
      .done  (done16),
      .bus   (b16.master)
   );

   twiddle_fetch #(.FFT_N(1024), .STAGE_NO(8)) dut1k (
      .clk   (clk),
      .rst   (rst),
      .start (start1k),
      .busy  (busy1k),
      .done  (done1k),
      .bus   (b1k.master)
   );

   always #5 clk = ~clk;

   // W_8^a for the 16-point stage-1 ROM, in Q1.15.
   function automatic int re16(input int a);
      case (a % 4)
         0:       return 32767;
         1:       return 23170;
         2:       return 0;
         default: return -23170;
      endcase
   endfunction

   function automatic int im16(input int a);
      case (a % 4)
         0:       return 0;
         1:       return -23170;
         2:       return -32767;
         default: return -23170;
      endcase
   endfunction

   // W_4^a for the 1024-point stage-8 ROM (two entries).
   function automatic int re1k(input int a);
      return (a % 2 == 0) ? 32767 : 0;
   endfunction

   function automatic int im1k(input int a);
      return (a % 2 == 0) ? 0 : -32767;
   endfunction

   assign b16.rom_w_re = 16'(re16(int'(b16.rom_addr)));
   assign b16.rom_w_im = 16'(im16(int'(b16.rom_addr)));
   assign b16.tw_ready = rdy16;
   assign b1k.rom_w_re = 16'(re1k(int'(b1k.rom_addr)));
   assign b1k.rom_w_im = 16'(im1k(int'(b1k.rom_addr)));
   assign b1k.tw_ready = rdy1k;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_idle16(input string tag);
      check({tag, "_busy"},     32'(busy16),         0);
      check({tag, "_done"},     32'(done16),         0);
      check({tag, "_rom_addr"}, 32'(b16.rom_addr),   0);
      check({tag, "_valid"},    32'(b16.tw_valid),   0);
      check({tag, "_re"},       32'(b16.tw_re),      0);
      check({tag, "_im"},       32'(b16.tw_im),      0);
      check({tag, "_index"},    32'(b16.tw_index),   0);
      check({tag, "_last"},     32'(b16.tw_last),    0);
   endtask

   // mode 0: ready high; 1: ready pattern 1,0,0,1,0,1; 2: ready low for 20 cycles;
   // 3: ready high with start re-pulsed while j=3 transfers.
   function automatic logic ready_for(input int mode, input int c);
      case (mode)
         1:       return (c % 6 == 0) || (c % 6 == 3) || (c % 6 == 5);
         2:       return (c >= 20);
         default: return 1'b1;
      endcase
   endfunction

   task automatic run_frame16(input string tag, input int mode);
      int          exp_j  = 0;
      int          ndone  = 0;
      int          done_c = -1;
      int          last_c = -1;
      logic        p_stall = 1'b0;
      logic [31:0] p_re = '0, p_im = '0, p_idx = '0, p_last = '0;
      start16 = 1'b1;
      rdy16   = 1'b1;
      step();
      start16 = 1'b0;
      for (int c = 0; c < 80; c++) begin
         start16 = 1'b0;
         rdy16   = ready_for(mode, c);
         if (c == 0) check({tag, "_busy_after_start"}, 32'(busy16), 1);
         if (mode == 0 && c >= 1 && c <= 8) check({tag, "_rom_addr"}, 32'(b16.rom_addr), (c - 1) % 4);
         if (mode == 0 && c == 1) check({tag, "_valid_c1"}, 32'(b16.tw_valid), 0);
         if (mode == 0 && c == 2) check({tag, "_valid_c2"}, 32'(b16.tw_valid), 1);
         if (mode == 2 && c == 19) begin
            // Two reads fill the FIFO (addresses 0 and 1); the address then parks.
            check({tag, "_parked_addr"},  32'(b16.rom_addr), 1);
            check({tag, "_parked_valid"}, 32'(b16.tw_valid), 1);
            check({tag, "_parked_index"}, 32'(b16.tw_index), 0);
         end
         if (p_stall) begin
            check({tag, "_hold_valid"}, 32'(b16.tw_valid), 1);
            check({tag, "_hold_re"},    32'(b16.tw_re),    p_re);
            check({tag, "_hold_im"},    32'(b16.tw_im),    p_im);
            check({tag, "_hold_index"}, 32'(b16.tw_index), p_idx);
            check({tag, "_hold_last"},  32'(b16.tw_last),  p_last);
         end
         if (b16.tw_valid && rdy16) begin
            check({tag, "_index"}, 32'(b16.tw_index), exp_j);
            check({tag, "_re"},    32'(b16.tw_re),    re16(exp_j));
            check({tag, "_im"},    32'(b16.tw_im),    im16(exp_j));
            check({tag, "_last"},  32'(b16.tw_last),  (exp_j == 7) ? 1 : 0);
            if (mode == 0) check({tag, "_xfer_cycle"}, c, 2 + exp_j);
            if (mode == 3 && exp_j == 3) start16 = 1'b1;
            if (exp_j == 7) last_c = c;
            exp_j++;
         end
         if (done16) begin
            ndone++;
            done_c = c;
            check({tag, "_busy_at_done"}, 32'(busy16), 0);
         end
         p_stall = b16.tw_valid && !rdy16;
         p_re    = 32'(b16.tw_re);
         p_im    = 32'(b16.tw_im);
         p_idx   = 32'(b16.tw_index);
         p_last  = 32'(b16.tw_last);
         if (done_c >= 0 && c == done_c + 3) break;
         step();
      end
      check({tag, "_transfers"}, exp_j, 8);
      check({tag, "_done_count"}, ndone, 1);
      check({tag, "_done_after_last"}, done_c, last_c + 1);
      check({tag, "_busy_end"}, 32'(busy16), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_j;
      int ndone;
      int done_c;
      bit seen;

      // Reset state
      rst = 1'b1;
      step();
      step();
      step();
      rst = 1'b0;
      check_idle16("reset");

      // Full-rate frame, backpressure pattern, long stall, ignored re-start
      run_frame16("full_rate", 0);
      run_frame16("toggle_ready", 1);
      run_frame16("long_stall", 2);
      run_frame16("restart_ignored", 3);

      // Reset during transfer j=4
      start16 = 1'b1;
      rdy16   = 1'b1;
      step();
      start16 = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (b16.tw_valid && b16.tw_index == 3'd4) begin
            seen = 1'b1;
            break;
         end
         step();
      end
      check("abort_reached_j4", 32'(seen), 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_idle16("abort");
      ndone = 0;
      for (int c = 0; c < 6; c++) begin
         if (done16) ndone++;
         step();
      end
      check("abort_no_done", ndone, 0);
      check("abort_busy", 32'(busy16), 0);
      run_frame16("after_abort", 0);

      // 1024-point, stage 8, random backpressure
      start1k = 1'b1;
      step();
      start1k = 1'b0;
      exp_j  = 0;
      ndone  = 0;
      done_c = -1;
      for (int c = 0; c < 5000; c++) begin
         rdy1k = 1'($urandom_range(0, 1));
         if (b1k.tw_valid && rdy1k) begin
            check("n1k_index", 32'(b1k.tw_index), exp_j);
            check("n1k_re",    32'(b1k.tw_re),    re1k(exp_j));
            check("n1k_im",    32'(b1k.tw_im),    im1k(exp_j));
            check("n1k_last",  32'(b1k.tw_last),  (exp_j == 511) ? 1 : 0);
            exp_j++;
         end
         if (done1k) begin
            ndone++;
            done_c = c;
         end
         if (done_c >= 0 && c == done_c + 3) break;
         step();
      end
      check("n1k_transfers", exp_j, 512);
      check("n1k_done_count", ndone, 1);
      check("n1k_busy_end", 32'(busy1k), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
